traffic_light_fsm: RTL and testbench

//  Two-way traffic-light controller that sits directly downstream of clk_divider.

---
 rtl/traffic_light_fsm_pkg.sv | 43 ++++
 rtl/seg7_decoder.sv | 32 +++
 rtl/traffic_light_fsm.sv | 212 +++++++++++++++++++++
 tb/tb_traffic_light_fsm.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_fsm_pkg.sv
// Shared definitions for the traffic-light controller: state encodings,
// light codes and small helpers. NIGHT_MODE_EN adds the FLASH state.
package traffic_light_fsm_pkg;

  typedef enum logic [2:0] {
    ST_NS_G  = 3'd0,
    ST_NS_Y  = 3'd1,
    ST_AR1   = 3'd2,
    ST_EW_G  = 3'd3,
    ST_EW_Y  = 3'd4,
    ST_AR2   = 3'd5,
    ST_WALK  = 3'd6
`ifdef NIGHT_MODE_EN
    , ST_FLASH = 3'd7
`endif
  } state_e;

  // Lamp codes {R,Y,G}
  localparam logic [2:0] LT_R   = 3'b100;
  localparam logic [2:0] LT_Y   = 3'b010;
  localparam logic [2:0] LT_G   = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  // Legal dwell range in ticks; the counter is 4 bits wide
  localparam int unsigned T_MIN = 1;
  localparam int unsigned T_MAX = 15;

  function automatic bit t_in_range(input int unsigned t);
    return (t >= T_MIN) && (t <= T_MAX);
  endfunction

  // Steady-state lamps for a state, packed as {ns, ew}
  function automatic logic [5:0] lights_of(input state_e s);
    case (s)
      ST_NS_G: return {LT_G, LT_R};
      ST_NS_Y: return {LT_Y, LT_R};
      ST_EW_G: return {LT_R, LT_G};
      ST_EW_Y: return {LT_R, LT_Y};
      default: return {LT_R, LT_R};
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to 7-segment decoder, active-low segments {g,f,e,d,c,b,a}.
// Shows 0-9 and A,b,C,d,E,F for 10-15.
module seg7_decoder (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg_n
);

  // Pure lookup from nibble to segment pattern
  always_comb begin
    o_seg_n = '1;
    case (i_val)
      4'h0: o_seg_n = ~7'h3F;
      4'h1: o_seg_n = ~7'h06;
      4'h2: o_seg_n = ~7'h5B;
      4'h3: o_seg_n = ~7'h4F;
      4'h4: o_seg_n = ~7'h66;
      4'h5: o_seg_n = ~7'h6D;
      4'h6: o_seg_n = ~7'h7D;
      4'h7: o_seg_n = ~7'h07;
      4'h8: o_seg_n = ~7'h7F;
      4'h9: o_seg_n = ~7'h6F;
      4'hA: o_seg_n = ~7'h77;
      4'hB: o_seg_n = ~7'h7C;
      4'hC: o_seg_n = ~7'h39;
      4'hD: o_seg_n = ~7'h5E;
      4'hE: o_seg_n = ~7'h79;
      4'hF: o_seg_n = ~7'h71;
      default: o_seg_n = '1;
    endcase
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-way traffic-light controller with latched pedestrian requests.
// clk_div is sampled as data; its synchronized rising edge is the step tick.
// Optional night flashing mode: define NIGHT_MODE_EN.
module traffic_light_fsm
  import traffic_light_fsm_pkg::*;
#(
  parameter int unsigned T_GREEN  = 5,
  parameter int unsigned T_YELLOW = 2,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_WALK   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_div,
  input  logic       ped_req_n,
`ifdef NIGHT_MODE_EN
  input  logic       night,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [3:0] countdown,
  output logic [6:0] hex0,
  output logic [2:0] state_dbg
);

  // Out-of-range dwell parameters stop elaboration
  if (!t_in_range(T_GREEN)) begin : g_bad_t_green
    $error("T_GREEN must be in 1..15");
  end
  if (!t_in_range(T_YELLOW)) begin : g_bad_t_yellow
    $error("T_YELLOW must be in 1..15");
  end
  if (!t_in_range(T_ALLRED)) begin : g_bad_t_allred
    $error("T_ALLRED must be in 1..15");
  end
  if (!t_in_range(T_WALK)) begin : g_bad_t_walk
    $error("T_WALK must be in 1..15");
  end

  localparam logic [3:0] C_GREEN  = 4'(T_GREEN  - 1);
  localparam logic [3:0] C_YELLOW = 4'(T_YELLOW - 1);
  localparam logic [3:0] C_ALLRED = 4'(T_ALLRED - 1);
  localparam logic [3:0] C_WALK   = 4'(T_WALK   - 1);

  function automatic logic [3:0] dwell_of(input state_e s);
    case (s)
      ST_NS_G, ST_EW_G: return C_GREEN;
      ST_NS_Y, ST_EW_Y: return C_YELLOW;
      ST_WALK:          return C_WALK;
      default:          return C_ALLRED;
    endcase
  endfunction

  logic       r_cd_s1, r_cd_s2, r_cd_d;
  logic       r_pb_s1, r_pb_s2, r_pb_d;
  logic       w_tick, w_press;

  state_e     r_state, w_next_state;
  logic [3:0] r_cnt, w_next_cnt;
  logic       r_next_dir, w_next_dir;
  logic       r_ped_pending, w_next_pending;
  logic [2:0] r_ns_light, r_ew_light;
  logic       r_ped_walk;
  logic [6:0] w_hex;

`ifdef NIGHT_MODE_EN
  logic r_nt_s1, r_nt_s2;
  logic r_flash_on, w_next_flash;
  logic w_night;

  // Night request synchronizer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nt_s1 <= 1'b0;
      r_nt_s2 <= 1'b0;
    end else begin
      r_nt_s1 <= night;
      r_nt_s2 <= r_nt_s1;
    end
  end

  assign w_night = r_nt_s2;
`endif

  // Two-flop synchronizers plus one history flop each for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cd_s1 <= 1'b0;
      r_cd_s2 <= 1'b0;
      r_cd_d  <= 1'b0;
      r_pb_s1 <= 1'b1;
      r_pb_s2 <= 1'b1;
      r_pb_d  <= 1'b1;
    end else begin
      r_cd_s1 <= clk_div;
      r_cd_s2 <= r_cd_s1;
      r_cd_d  <= r_cd_s2;
      r_pb_s1 <= ped_req_n;
      r_pb_s2 <= r_pb_s1;
      r_pb_d  <= r_pb_s2;
    end
  end

  assign w_tick  = r_cd_s2 & ~r_cd_d;
  assign w_press = r_pb_d & ~r_pb_s2;

  // Next state, dwell count, walk return direction and request latch
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_dir   = r_next_dir;
`ifdef NIGHT_MODE_EN
    w_next_flash = r_flash_on;
`endif
    if (w_tick) begin
`ifdef NIGHT_MODE_EN
      if (w_night) begin
        w_next_state = ST_FLASH;
        w_next_cnt   = '0;
        w_next_flash = (r_state == ST_FLASH) ? ~r_flash_on : 1'b1;
      end else if (r_state == ST_FLASH) begin
        w_next_state = ST_AR2;
        w_next_cnt   = C_ALLRED;
      end else
`endif
      if (r_cnt != '0) begin
        w_next_cnt = r_cnt - 4'd1;
      end else begin
        case (r_state)
          ST_NS_G: w_next_state = ST_NS_Y;
          ST_NS_Y: w_next_state = ST_AR1;
          ST_AR1: begin
            if (r_ped_pending) begin
              w_next_state = ST_WALK;
              w_next_dir   = 1'b1;
            end else begin
              w_next_state = ST_EW_G;
            end
          end
          ST_EW_G: w_next_state = ST_EW_Y;
          ST_EW_Y: w_next_state = ST_AR2;
          ST_AR2: begin
            if (r_ped_pending) begin
              w_next_state = ST_WALK;
              w_next_dir   = 1'b0;
            end else begin
              w_next_state = ST_NS_G;
            end
          end
          ST_WALK: w_next_state = r_next_dir ? ST_EW_G : ST_NS_G;
          default: w_next_state = ST_AR2;
        endcase
        w_next_cnt = dwell_of(w_next_state);
      end
    end

    // Entering WALK clears the request even against a same-cycle press
    w_next_pending = r_ped_pending;
    if (w_next_state == ST_WALK && r_state != ST_WALK)
      w_next_pending = 1'b0;
`ifdef NIGHT_MODE_EN
    else if (r_state == ST_FLASH || w_next_state == ST_FLASH)
      w_next_pending = 1'b0;
`endif
    else if (w_press && r_state != ST_WALK)
      w_next_pending = 1'b1;
  end

  // State register with lamps registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_AR2;
      r_cnt         <= C_ALLRED;
      r_next_dir    <= 1'b0;
      r_ped_pending <= 1'b0;
      r_ns_light    <= LT_R;
      r_ew_light    <= LT_R;
      r_ped_walk    <= 1'b0;
`ifdef NIGHT_MODE_EN
      r_flash_on    <= 1'b0;
`endif
    end else begin
      r_state                  <= w_next_state;
      r_cnt                    <= w_next_cnt;
      r_next_dir               <= w_next_dir;
      r_ped_pending            <= w_next_pending;
      {r_ns_light, r_ew_light} <= lights_of(w_next_state);
      r_ped_walk               <= (w_next_state == ST_WALK);
`ifdef NIGHT_MODE_EN
      r_flash_on <= w_next_flash;
      if (w_next_state == ST_FLASH) begin
        r_ns_light <= w_next_flash ? LT_Y : LT_OFF;
        r_ew_light <= w_next_flash ? LT_Y : LT_OFF;
      end
`endif
    end
  end

  seg7_decoder u_seg7 (
    .i_val   (r_cnt),
    .o_seg_n (w_hex)
  );

  assign ns_light  = r_ns_light;
  assign ew_light  = r_ew_light;
  assign ped_walk  = r_ped_walk;
  assign countdown = r_cnt;
  assign hex0      = w_hex;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: tick-level reference model of the light
// sequence, pedestrian latch and display, driven by a 20-clk clk_div wave.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_div;
  logic       ped_req_n;
`ifdef NIGHT_MODE_EN
  logic       night = 1'b0;
`endif
  logic [2:0] ns_light, ew_light, state_dbg;
  logic       ped_walk;
  logic [3:0] countdown;
  logic [6:0] hex0;
  logic [20:0] w_obs;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int DUR [8] = '{5, 2, 1, 5, 2, 1, 4, 1};
  localparam logic [6:0] SEG_AH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state (states numbered in the documented order)
  int m_state, m_rem;
  bit m_pend, m_dir, m_flash, m_night;

  traffic_light_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .clk_div   (clk_div),
    .ped_req_n (ped_req_n),
`ifdef NIGHT_MODE_EN
    .night     (night),
`endif
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .ped_walk  (ped_walk),
    .countdown (countdown),
    .hex0      (hex0),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  assign w_obs = {state_dbg, countdown, ns_light, ew_light, ped_walk, hex0};

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_state = 5; m_rem = DUR[5] - 1; m_pend = 0; m_dir = 0; m_flash = 0;
  endtask

  task automatic model_tick(input bit press);
    int old;
    bit enter_walk;
    old = m_state;
    enter_walk = 0;
    if (m_night) begin
      m_flash = (old == 7) ? !m_flash : 1'b1;
      m_state = 7; m_rem = 0; m_pend = 0;
      return;
    end
    if (old == 7) begin
      m_state = 5; m_rem = DUR[5] - 1; m_pend = 0;
      return;
    end
    if (m_rem > 0) m_rem--;
    else begin
      if ((old == 2 || old == 5) && m_pend) begin
        m_dir = (old == 2); m_state = 6; enter_walk = 1;
      end else if (old == 6) m_state = m_dir ? 3 : 0;
      else m_state = (old + 1) % 6;
      m_rem = DUR[m_state] - 1;
    end
    if (enter_walk) m_pend = 0;
    else if (press && old != 6) m_pend = 1;
  endtask

  function automatic logic [20:0] exp_vec();
    logic [2:0] ns, ew;
    case (m_state)
      0: begin ns = 3'b001; ew = 3'b100; end
      1: begin ns = 3'b010; ew = 3'b100; end
      3: begin ns = 3'b100; ew = 3'b001; end
      4: begin ns = 3'b100; ew = 3'b010; end
      7: begin ns = m_flash ? 3'b010 : 3'b000; ew = ns; end
      default: begin ns = 3'b100; ew = 3'b100; end
    endcase
    return {3'(m_state), 4'(m_rem), ns, ew, (m_state == 6), ~SEG_AH[m_rem]};
  endfunction

  // Rising clk_div edge; returns just after the clk edge where the tick acts
  task automatic tick_rise(input bit press_same);
    @(negedge clk);
    clk_div = 1'b1;
    if (press_same) ped_req_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_tick(press_same);
  endtask

  task automatic tick_fall();
    repeat (7) @(negedge clk);
    clk_div = 1'b0;
    ped_req_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Button press placed in the low phase, away from any tick
  task automatic do_press();
    @(negedge clk);
    ped_req_n = 1'b0;
    repeat (5) @(negedge clk);
    ped_req_n = 1'b1;
    repeat (5) @(negedge clk);
    if (m_state != 6 && m_state != 7) m_pend = 1;
  endtask

  task automatic advance_to(input int st, input string tag);
    for (int i = 0; i < 30 && m_state != st; i++) begin
      tick_rise(0);
      n_tests++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h expected %h", tag, i, w_obs, exp_vec());
      end
      tick_fall();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clk_div = 1'b0; ped_req_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (w_obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", w_obs, exp_vec());
    end
    rst = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (w_obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_sequence();
    for (int i = 0; i < 14; i++) begin
      tick_rise(0);
      n_tests++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL seq[%0d]: got %h expected %h", i, w_obs, exp_vec());
      end
      tick_fall();
    end
  endtask

  task automatic test_ped_walk();
    advance_to(0, "walk_pre");
    do_press();
    advance_to(6, "walk_in");
    advance_to(3, "walk_out");
    n_tests++;
    if (state_dbg !== 3'd3 || ped_walk !== 1'b0) begin
      n_fail++;
      $display("FAIL walk_exit: got state %0d walk %b expected state 3 walk 0", state_dbg, ped_walk);
    end
    advance_to(0, "walk_nopend");
  endtask

  task automatic test_press_in_walk();
    do_press();
    advance_to(6, "inwalk_pre");
    do_press();
    advance_to(5, "inwalk_ar2");
    advance_to(0, "inwalk_ns");
    n_tests++;
    if (state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL inwalk_ignored: got state %0d expected 0", state_dbg);
    end
  endtask

  task automatic test_press_enter_walk();
    do_press();
    advance_to(2, "entry_pre");
    tick_rise(1);
    n_tests++;
    if (w_obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL entry_tick: got %h expected %h", w_obs, exp_vec());
    end
    tick_fall();
    advance_to(5, "entry_ar2");
    advance_to(0, "entry_ns");
    n_tests++;
    if (state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL entry_clear: got state %0d expected 0", state_dbg);
    end
  endtask

  task automatic test_reset_mid();
    advance_to(3, "rstmid_pre");
    for (int i = 0; i < 5 && m_rem != 2; i++) begin
      tick_rise(0);
      n_tests++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL rstmid_cnt[%0d]: got %h expected %h", i, w_obs, exp_vec());
      end
      tick_fall();
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (w_obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL rst_async: got %h expected %h", w_obs, exp_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_rise(0);
      n_tests++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_restart[%0d]: got %h expected %h", i, w_obs, exp_vec());
      end
      tick_fall();
    end
  endtask

  task automatic test_random();
    bit p;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(3) == 0) do_press();
      p = ($urandom_range(7) == 0);
      tick_rise(p);
      n_tests++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand[%0d]: got %h expected %h", i, w_obs, exp_vec());
      end
      tick_fall();
    end
  endtask

`ifdef NIGHT_MODE_EN
  task automatic set_night(input bit v);
    @(negedge clk);
    night = v;
    m_night = v;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_night();
    advance_to(0, "night_pre");
    do_press();
    set_night(1);
    for (int i = 0; i < 5; i++) begin
      tick_rise(0);
      n_tests++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL flash[%0d]: got %h expected %h", i, w_obs, exp_vec());
      end
      tick_fall();
    end
    set_night(0);
    for (int i = 0; i < 2; i++) begin
      tick_rise(0);
      n_tests++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL night_exit[%0d]: got %h expected %h", i, w_obs, exp_vec());
      end
      tick_fall();
    end
  endtask
`endif

  initial begin
    m_night = 0;
    test_reset();
    test_sequence();
    test_ped_walk();
    test_press_in_walk();
    test_press_enter_walk();
    test_reset_mid();
    test_random();
`ifdef NIGHT_MODE_EN
    test_night();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
